branch_pc_unit: RTL and testbench
=================================

// Module: branch_pc_unit
// PURPOSE
//  Program-counter stage of the simple single CPU. Holds PC, fetches from instruction
//  memory over a req/ack handshake, and picks next PC: PC+4, branch target or jump target.
//  Consumes the word-aligned branch offset from the shift-left-two stage; branch target is
//  PC+4 plus that offset. A fetch timeout counter flags a hung memory.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  TIMEOUT   16             max FETCH cycles without ack before error (>=1)
//  CNT_W     5              width of timeout counter (must hold TIMEOUT)
// PORTS
//  clk_i             in   1   clock, rising edge
//  rst_i             in   1   asynchronous reset, active-low
//  imem_req_o        out  1   fetch request, high in FETCH only
//  imem_addr_o       out  32  fetch address (= pc_o)
//  imem_ack_i        in   1   memory ack; instruction valid this cycle
//  instr_valid_o     out  1   high in EXEC: decoder outputs below are sampled this cycle
//  branch_i          in   1   instruction is a conditional branch
//  zero_i            in   1   ALU zero flag
//  shifted_offset_i  in   32  sign-extended offset << 2 (from shift-left-two stage)
//  jump_i            in   1   instruction is a jump
//  jump_target_i     in   26  jump instruction index field
//  halt_i            in   1   stop fetching after current instruction
//  pc_o              out  32  current PC
//  pc_plus4_o        out  32  pc_o + 4, combinational
//  halted_o          out  1   high in HALT
//  err_o             out  1   sticky; fetch timeout occurred
// BEHAVIOUR
//  - Reset (rst_i=0, async): pc_o=RESET_PC, state=IDLE, counter=0, err_o=0;
//    imem_req_o, instr_valid_o, halted_o drop to 0 at once, no clock needed.
//  - States: IDLE, FETCH, EXEC, HALT. Outputs decode from state only (Moore).
//  - IDLE: one cycle after reset release, then FETCH.
//  - FETCH: imem_req_o=1, imem_addr_o=pc_o held stable. imem_ack_i=1 -> EXEC, counter=0.
//    No ack -> counter+1; no ack when counter==TIMEOUT-1 -> HALT, err_o=1.
//  - EXEC: one cycle, instr_valid_o=1. At clock edge pc_o <= next_pc; go to FETCH,
//    or HALT if halt_i=1 (pc_o still updated).
//  - next_pc priority: jump_i -> {pc_plus4[31:28], jump_target_i, 2'b00};
//    else branch_i&zero_i -> pc_plus4 + {shifted_offset_i[31:2],2'b00};
//    else pc_plus4. 32-bit add, carry dropped (wraps mod 2^32).
//  - shifted_offset_i[1:0] ignored (forced 0); pc_o[1:0] stays 00 if RESET_PC aligned.
//  - jump_i and branch_i both high: jump wins.
//  - Control inputs ignored outside EXEC; imem_ack_i ignored outside FETCH.
//  - HALT: absorbing; pc_o frozen, halted_o=1, imem_req_o=0. Exit only by reset.
//  - Min throughput: 2 cycles per instruction (FETCH with immediate ack, then EXEC).
//  - Reset mid-FETCH or mid-EXEC: abort, no PC update, restart from RESET_PC.
// TESTING
//  1 Reset, release, ack immediately each FETCH -> req low 1 cycle, then pc_o 0,4,8,12
//    on successive EXEC exits; instr_valid_o alternates with req.
//  2 At pc=0x08 EXEC: branch_i=1, zero_i=1, offset=0x10 -> pc_o=0x1C; repeat with
//    zero_i=0 -> pc_o=0x0C.
//  3 At pc=0x00: branch taken, offset=0xFFFF_FFF0 -> pc_o=0xFFFF_FFF4 (wrap); offset
//    0x13 -> treated as 0x10, pc_o=0x14.
//  4 At pc=0x1000_0004: jump_i=1, branch_i=1, zero_i=1, jump_target_i=26'h0000040
//    -> pc_o=0x1000_0100 (jump priority).
//  5 Hold imem_ack_i=0 with TIMEOUT=16 -> exactly 16 FETCH cycles, then halted_o=1,
//    err_o=1, req=0; later ack ignored.
//  6 halt_i=1 in EXEC at pc=0x20 -> pc_o=0x24, HALT; assert rst_i=0 mid-FETCH
//    -> req drops same cycle, pc_o=RESET_PC.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Program-counter stage: holds PC, fetches over a req/ack handshake and selects
// the next PC (sequential, taken branch or jump). A fetch watchdog halts on a hung memory.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  output logic        instr_valid_o,
  input  logic        branch_i,
  input  logic        zero_i,
  input  logic [31:0] shifted_offset_i,
  input  logic        jump_i,
  input  logic [25:0] jump_target_i,
  input  logic        halt_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        halted_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err;
  logic             w_err_set;
  logic             w_pc_load;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_br_target;
  logic [31:0]      w_jmp_target;
  logic [31:0]      w_next_pc;
  logic             w_unused_ofs;

  // Offset low bits are forced to zero so the PC can never lose word alignment.
  assign w_unused_ofs = ^shifted_offset_i[1:0];

  always_comb begin
    w_pc_plus4   = r_pc + 32'd4;
    w_br_target  = w_pc_plus4 + {shifted_offset_i[31:2], 2'b00};
    w_jmp_target = {w_pc_plus4[31:28], jump_target_i, 2'b00};
    if (jump_i)
      w_next_pc = w_jmp_target;
    else if (branch_i && zero_i)
      w_next_pc = w_br_target;
    else
      w_next_pc = w_pc_plus4;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_set   = 1'b0;
    w_pc_load   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
        w_cnt_nxt   = '0;
      end
      S_FETCH: begin
        if (imem_ack_i) begin
          w_state_nxt = S_EXEC;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          // Memory never answered: park in HALT with the sticky error raised.
          w_state_nxt = S_HALT;
          w_err_set   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_EXEC: begin
        w_pc_load   = 1'b1;
        w_state_nxt = halt_i ? S_HALT : S_FETCH;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_pc_load) r_pc  <= w_next_pc;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign imem_req_o    = (r_state == S_FETCH);
  assign instr_valid_o = (r_state == S_EXEC);
  assign halted_o      = (r_state == S_HALT);
  assign imem_addr_o   = r_pc;
  assign pc_o          = r_pc;
  assign pc_plus4_o    = w_pc_plus4;
  assign err_o         = r_err;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: vector table, randomized instruction
// stream against a next-PC model, and handwritten reset/halt/timeout sequences.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req, valid, halted, err;
  logic [31:0] addr, pc, pc_p4;
  logic        ack = 1'b0, br = 1'b0, zr = 1'b0, jmp = 1'b0, hlt = 1'b0;
  logic [31:0] off = '0;
  logic [25:0] tgt = '0;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  branch_pc_unit #(.RESET_PC(32'h0), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack),
    .instr_valid_o(valid),
    .branch_i(br), .zero_i(zr), .shifted_offset_i(off),
    .jump_i(jmp), .jump_target_i(tgt), .halt_i(hlt),
    .pc_o(pc), .pc_plus4_o(pc_p4), .halted_o(halted), .err_o(err)
  );

  typedef struct {
    logic [31:0] start_pc;
    logic        b, z;
    logic [31:0] ofs;
    logic        j;
    logic [25:0] t;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain-arithmetic statement of the next-PC rules.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic b, input logic z,
                                           input logic [31:0] o, input logic j, input logic [25:0] t);
    logic [31:0] seq;
    seq = p + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ({6'd0, t} * 32'd4);
    if (b && z) return seq + (o & 32'hFFFF_FFFC);
    return seq;
  endfunction

  task automatic quiet();
    br = 0; zr = 0; jmp = 0; hlt = 0; off = '0; tgt = '0;
  endtask

  task automatic garbage();
    br = 1'($urandom); zr = 1'($urandom); jmp = 1'($urandom); hlt = 1'($urandom);
    off = $urandom; tgt = 26'($urandom);
  endtask

  // Entered at a negedge while the DUT is in FETCH; leaves at the negedge after EXEC.
  task automatic do_instr(input logic b, input logic z, input logic [31:0] o, input logic j,
                          input logic [25:0] t, input logic h, input int dly, input bit noisy);
    chk("fetch_req", req, 1);
    chk("fetch_addr", addr, m_pc);
    chk("pc_plus4", pc_p4, m_pc + 32'd4);
    for (int i = 0; i < dly; i++) begin
      ack = 0;
      if (noisy) garbage();
      @(negedge clk);
      chk("wait_req", req, 1);
      chk("wait_valid", valid, 0);
      chk("wait_pc", pc, m_pc);
    end
    ack = 1;
    if (noisy) garbage();
    @(negedge clk);
    chk("exec_valid", valid, 1);
    chk("exec_req", req, 0);
    chk("exec_pc", pc, m_pc);
    ack = noisy ? 1'($urandom) : 1'b0;
    br = b; zr = z; off = o; jmp = j; tgt = t; hlt = h;
    @(negedge clk);
    m_pc = ref_next(m_pc, b, z, o, j, t);
    ack = 0;
    quiet();
    chk("next_pc", pc, m_pc);
    if (h) begin
      chk("halt_flag", halted, 1);
      chk("halt_req", req, 0);
    end else begin
      chk("refetch_req", req, 1);
    end
  endtask

  task automatic steer(input logic [31:0] target);
    do_instr(1, 1, target - m_pc - 32'd4, 0, '0, 0, 0, 0);
  endtask

  // Leaves at the first FETCH negedge after an IDLE cycle.
  task automatic do_reset();
    ack = 0;
    quiet();
    rst_n = 0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", req, 0);
    chk("rst_valid", valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1;
    m_pc = 32'h0;
    #1;
    chk("idle_req", req, 0);
    @(negedge clk);
    chk("first_fetch_req", req, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vecs[0] = '{32'h0000_0008, 1'b1, 1'b1, 32'h0000_0010, 1'b0, 26'h0, 32'h0000_001C};
    vecs[1] = '{32'h0000_0008, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 26'h0, 32'h0000_000C};
    vecs[2] = '{32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0, 26'h0, 32'hFFFF_FFF4};
    vecs[3] = '{32'h0000_0000, 1'b1, 1'b1, 32'h0000_0013, 1'b0, 26'h0, 32'h0000_0014};
    vecs[4] = '{32'h1000_0004, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 26'h0000040, 32'h1000_0100};
    vecs[5] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 26'h0, 32'h0000_0000};
    vecs[6] = '{32'hF000_0000, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 26'h0, 32'hF000_0004};
    vecs[7] = '{32'h0FFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 26'h3FF_FFFF, 32'h1FFF_FFFC};
    vecs[8] = '{32'h3000_0010, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 26'h0, 32'h3000_0000};

    m_pc = 32'h0;
    @(negedge clk);
    do_reset();

    // Sequential fetch with immediate ack.
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", pc, 32'(i * 4));
      do_instr(0, 0, '0, 0, '0, 0, 0, 0);
    end

    // Table of next-PC cases, each reached by a branch from wherever the PC sits.
    for (int i = 0; i < 9; i++) begin
      steer(vecs[i].start_pc);
      do_instr(vecs[i].b, vecs[i].z, vecs[i].ofs, vecs[i].j, vecs[i].t, 0, i % 3, 0);
      chk("vec_pc", pc, vecs[i].exp_pc);
    end

    // Randomized stream: random controls, ack latency and out-of-phase noise.
    for (int i = 0; i < 200; i++) begin
      do_instr(1'($urandom), 1'($urandom), $urandom, ($urandom_range(0, 3) == 0),
               26'($urandom), 0, $urandom_range(0, 6), 1);
    end
    chk("no_err_after_random", err, 0);

    // Halt in EXEC at 0x20: PC still advances, then frozen.
    do_reset();
    steer(32'h20);
    do_instr(0, 0, '0, 0, '0, 1, 0, 0);
    chk("halt_pc", pc, 32'h24);
    ack = 1;
    jmp = 1;
    tgt = 26'h123;
    repeat (3) @(negedge clk);
    chk("halt_stays", halted, 1);
    chk("halt_no_req", req, 0);
    chk("halt_pc_frozen", pc, 32'h24);
    chk("halt_no_err", err, 0);
    ack = 0;
    quiet();

    // Reset mid-FETCH drops req without a clock edge.
    do_reset();
    steer(32'h80);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midfetch_req", req, 0);
    chk("midfetch_pc", pc, 32'h0);

    // Reset mid-EXEC aborts the PC update.
    do_reset();
    steer(32'h40);
    ack = 1;
    @(negedge clk);
    ack = 0;
    chk("midexec_valid_pre", valid, 1);
    jmp = 1;
    tgt = 26'h3FF;
    #2 rst_n = 0;
    #1;
    chk("midexec_valid", valid, 0);
    chk("midexec_pc", pc, 32'h0);
    @(posedge clk);
    #1;
    chk("midexec_pc_held", pc, 32'h0);
    quiet();

    // Fetch timeout: exactly TIMEOUT request cycles, then sticky error.
    do_reset();
    cnt = 0;
    while (req === 1'b1 && cnt < 40) begin
      cnt++;
      if (cnt == 16) chk("err_before_timeout", err, 0);
      @(negedge clk);
    end
    chk("timeout_fetch_cycles", 32'(cnt), 32'd16);
    chk("timeout_halted", halted, 1);
    chk("timeout_err", err, 1);
    chk("timeout_req", req, 0);
    ack = 1;
    repeat (3) @(negedge clk);
    chk("timeout_ack_ignored", halted, 1);
    chk("timeout_err_sticky", err, 1);
    chk("timeout_pc", pc, 32'h0);
    ack = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
